// File: rtl/wide_op_sequencer.sv
// Sequences a W-bit external ALU over two cycles to perform 2*W-bit add, subtract and shifts.
// The low byte goes first except for right shifts; the ALU carry/shift-out links the two halves.
module wide_op_sequencer #(
  parameter int W = 8
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic [1:0]     OpSel,
  input  logic [2*W-1:0] OperandA,
  input  logic [2*W-1:0] OperandB,
  output logic [W-1:0]   AluA,
  output logic [W-1:0]   AluB,
  output logic [1:0]     AluOp,
  output logic           AluSCin,
  input  logic [W-1:0]   AluOut,
  input  logic           AluSCout,
  output logic           Busy,
  output logic           Done,
  output logic [2*W-1:0] Result,
  output logic           CarryOut,
  output logic           Zero16
);

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_LSH = 2'b10;
  localparam logic [1:0] ALU_RSH = 2'b11;

  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b01;
  localparam logic [1:0] SEL_LSH = 2'b10;
  localparam logic [1:0] SEL_RSH = 2'b11;

  typedef enum logic [1:0] {IDLE, FIRST, SECOND, DONE} state_t;

  state_t         state, state_next;
  logic [2*W-1:0] op_a, op_b;
  logic [1:0]     op_sel;
  logic [W-1:0]   scratch_lo, scratch_hi;
  logic           link;
  logic           use_hi;
  logic           in_op;
  logic [W-1:0]   byte_a, byte_b;
  logic [2*W-1:0] result_next;

  assign Busy = (state == FIRST) || (state == SECOND);
  assign Done = (state == DONE);

  always_comb begin
    state_next  = state;
    use_hi      = 1'b0;
    in_op       = 1'b0;
    AluA        = '0;
    AluB        = '0;
    AluOp       = ALU_ADD;
    AluSCin     = 1'b0;
    case (state)
      IDLE, DONE: state_next = Start ? FIRST : IDLE;
      FIRST: begin
        state_next = SECOND;
        in_op      = 1'b1;
        use_hi     = (op_sel == SEL_RSH);
      end
      SECOND: begin
        state_next = DONE;
        in_op      = 1'b1;
        use_hi     = (op_sel != SEL_RSH);
      end
      default: state_next = IDLE;
    endcase

    byte_a = use_hi ? op_a[2*W-1:W] : op_a[W-1:0];
    byte_b = use_hi ? op_b[2*W-1:W] : op_b[W-1:0];

    // Subtraction is done as A + ~B + 1 because the ALU SUB ignores SC_in.
    if (in_op) begin
      AluA = byte_a;
      case (op_sel)
        SEL_ADD: begin
          AluB    = byte_b;
          AluSCin = (state == SECOND) ? link : 1'b0;
        end
        SEL_SUB: begin
          AluB    = ~byte_b;
          AluSCin = (state == SECOND) ? link : 1'b1;
        end
        SEL_LSH: begin
          AluOp   = ALU_LSH;
          AluSCin = (state == SECOND) ? link : 1'b0;
        end
        default: begin
          AluOp   = ALU_RSH;
          AluSCin = (state == SECOND) ? link : 1'b0;
        end
      endcase
    end

    result_next = use_hi ? {AluOut, scratch_lo} : {scratch_hi, AluOut};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      op_sel     <= '0;
      scratch_lo <= '0;
      scratch_hi <= '0;
      link       <= 1'b0;
      Result     <= '0;
      CarryOut   <= 1'b0;
      Zero16     <= 1'b1;
    end else begin
      state <= state_next;
      if ((state == IDLE || state == DONE) && Start) begin
        op_a   <= OperandA;
        op_b   <= OperandB;
        op_sel <= OpSel;
      end
      if (in_op) begin
        if (use_hi) scratch_hi <= AluOut;
        else        scratch_lo <= AluOut;
        link <= AluSCout;
      end
      // The second half arrives on the same edge that enters DONE, so merge it directly.
      if (state == SECOND) begin
        Result   <= result_next;
        CarryOut <= AluSCout;
        Zero16   <= (result_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_wide_op_sequencer.sv
// Directed bench for wide_op_sequencer with a behavioural 8-bit ALU attached.
// Table vectors cover each operation; hand sequences cover reset and back-to-back starts.
module tb_wide_op_sequencer;

  localparam int W = 8;

  logic           Clk = 1'b0;
  logic           Reset, Start;
  logic [1:0]     OpSel;
  logic [2*W-1:0] OperandA, OperandB;
  logic [W-1:0]   AluA, AluB, AluOut;
  logic [1:0]     AluOp;
  logic           AluSCin, AluSCout;
  logic           Busy, Done, CarryOut, Zero16;
  logic [2*W-1:0] Result;

  int nVectors = 0;
  int nMiscompares = 0;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] expResult;
    logic        expCarry;
  } vec_t;

  vec_t vecs[10];

  always #5 Clk = ~Clk;

  wide_op_sequencer #(.W(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .OpSel(OpSel),
    .OperandA(OperandA), .OperandB(OperandB),
    .AluA(AluA), .AluB(AluB), .AluOp(AluOp), .AluSCin(AluSCin),
    .AluOut(AluOut), .AluSCout(AluSCout),
    .Busy(Busy), .Done(Done), .Result(Result), .CarryOut(CarryOut), .Zero16(Zero16)
  );

  // Reference ALU: ADD uses SC_in as carry, SUB ignores it, shifts insert SC_in.
  always_comb begin
    AluOut   = '0;
    AluSCout = 1'b0;
    case (AluOp)
      2'b00: {AluSCout, AluOut} = {1'b0, AluA} + {1'b0, AluB} + {8'd0, AluSCin};
      2'b01: {AluSCout, AluOut} = {1'b0, AluA} - {1'b0, AluB};
      2'b10: begin AluOut = {AluA[W-2:0], AluSCin}; AluSCout = AluA[W-1]; end
      default: begin AluOut = {AluSCin, AluA[W-1:1]}; AluSCout = AluA[0]; end
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drives one Start request on the falling edge; the next rising edge samples it.
  task automatic applyStimulus(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge Clk);
    OpSel    = op;
    OperandA = a;
    OperandB = b;
    Start    = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{2'b00, 16'h00FF, 16'h0001, 16'h0100, 1'b0};
    vecs[1] = '{2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    vecs[2] = '{2'b00, 16'h1234, 16'h4321, 16'h5555, 1'b0};
    vecs[3] = '{2'b01, 16'h1000, 16'h0001, 16'h0FFF, 1'b1};
    vecs[4] = '{2'b01, 16'h0000, 16'h0001, 16'hFFFF, 1'b0};
    vecs[5] = '{2'b01, 16'h5000, 16'h5000, 16'h0000, 1'b1};
    vecs[6] = '{2'b10, 16'h8080, 16'h0000, 16'h0100, 1'b1};
    vecs[7] = '{2'b10, 16'h4001, 16'h0000, 16'h8002, 1'b0};
    vecs[8] = '{2'b11, 16'h0101, 16'h0000, 16'h0080, 1'b1};
    vecs[9] = '{2'b11, 16'h8000, 16'h0000, 16'h4000, 1'b0};

    Reset = 1'b1; Start = 1'b0; OpSel = '0; OperandA = '0; OperandB = '0;
    repeat (2) @(posedge Clk);
    #1;
    checkOutput("reset Busy", 32'(Busy), 32'd0);
    checkOutput("reset Done", 32'(Done), 32'd0);
    checkOutput("reset Result", 32'(Result), 32'h0);
    checkOutput("reset CarryOut", 32'(CarryOut), 32'd0);
    checkOutput("reset Zero16", 32'(Zero16), 32'd1);
    checkOutput("idle AluA", 32'(AluA), 32'h0);
    @(negedge Clk) Reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      for (int c = 1; c <= 3; c++) begin
        checkOutput($sformatf("vec%0d Done c%0d", i, c), 32'(Done), 32'(c == 3));
        checkOutput($sformatf("vec%0d Busy c%0d", i, c), 32'(Busy), 32'(c != 3));
        if (c != 3) nextCycle();
      end
      checkOutput($sformatf("vec%0d Result", i), 32'(Result), 32'(vecs[i].expResult));
      checkOutput($sformatf("vec%0d CarryOut", i), 32'(CarryOut), 32'(vecs[i].expCarry));
      checkOutput($sformatf("vec%0d Zero16", i), 32'(Zero16), 32'(vecs[i].expResult == 16'h0));
      nextCycle();
      checkOutput($sformatf("vec%0d idle Done", i), 32'(Done), 32'd0);
      checkOutput($sformatf("vec%0d hold Result", i), 32'(Result), 32'(vecs[i].expResult));
    end

    // Reset asserted while in SECOND aborts the operation.
    applyStimulus(2'b00, 16'h1234, 16'h4321);
    nextCycle();
    checkOutput("abort in SECOND Busy", 32'(Busy), 32'd1);
    Reset = 1'b1;
    nextCycle();
    checkOutput("abort Busy", 32'(Busy), 32'd0);
    checkOutput("abort Done", 32'(Done), 32'd0);
    checkOutput("abort Result", 32'(Result), 32'h0);
    checkOutput("abort Zero16", 32'(Zero16), 32'd1);
    Reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      checkOutput($sformatf("abort no Done c%0d", c), 32'(Done), 32'd0);
    end

    // Reset wins over Start on the same edge.
    @(negedge Clk);
    Reset = 1'b1; Start = 1'b1; OpSel = 2'b00; OperandA = 16'h0001; OperandB = 16'h0001;
    nextCycle();
    checkOutput("reset vs start Busy", 32'(Busy), 32'd0);
    Reset = 1'b0; Start = 1'b0;

    // Start held through Busy with operands changed mid-op, then restarted from DONE.
    @(negedge Clk);
    OpSel = 2'b00; OperandA = 16'h00FF; OperandB = 16'h0001; Start = 1'b1;
    nextCycle();
    OperandA = 16'h1111; OperandB = 16'h1111;
    nextCycle();
    nextCycle();
    checkOutput("b2b first Done", 32'(Done), 32'd1);
    checkOutput("b2b first Result", 32'(Result), 32'h0100);
    nextCycle();
    Start = 1'b0;
    checkOutput("b2b restart Busy", 32'(Busy), 32'd1);
    checkOutput("b2b c4 Done", 32'(Done), 32'd0);
    nextCycle();
    checkOutput("b2b c5 Done", 32'(Done), 32'd0);
    nextCycle();
    checkOutput("b2b second Done", 32'(Done), 32'd1);
    checkOutput("b2b second Result", 32'(Result), 32'h2222);
    checkOutput("b2b second CarryOut", 32'(CarryOut), 32'd0);
    nextCycle();
    checkOutput("b2b back to idle", 32'(Done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
